// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants, the position type, and the GPU screen
// geometry so the timing generator and the pixel pipeline agree on one source.
package vga_pkg;

    typedef logic [9:0] pos_t;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam int SCREEN_W = 512;
    localparam int SCREEN_H = 256;

endpackage

// File: rtl/vga_timing_sync_delay.sv
// N-deep, W-wide shift register that loads an idle pattern on reset; depth 0
// degenerates to a straight wire so callers need no special case.
module sync_delay
    import vga_pkg::*;
#(
    parameter int             DEPTH = 1,
    parameter int             W     = 2,
    parameter logic [W-1:0]   IDLE  = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    // Keep at least one stage so the array is never zero-sized.
    localparam int N = (DEPTH > 0) ? DEPTH : 1;

    logic [W-1:0] stage_q [N];
    logic [W-1:0] stage_d [N];

    always_comb begin
        stage_d[0] = i_d;
        for (int i = 1; i < N; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                stage_q[i] <= IDLE;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign o_q = (DEPTH == 0) ? i_d : stage_q[N-1];

endmodule

// File: rtl/vga_timing.sv
// Free-running raster timing: h/v counters, one registered output stage for all
// strobes and positions, and an extra programmable delay on the sync pins only.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int H_FRONT    = vga_pkg::H_FRONT,
    parameter int H_SYNC     = vga_pkg::H_SYNC,
    parameter int H_BACK     = vga_pkg::H_BACK,
    parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int V_FRONT    = vga_pkg::V_FRONT,
    parameter int V_SYNC     = vga_pkg::V_SYNC,
    parameter int V_BACK     = vga_pkg::V_BACK,
    parameter bit SYNC_NEG   = 1'b1,
    parameter int SYNC_DELAY = 1
) (
    input  logic clk,
    input  logic rst,
    output logic o_hsync,
    output logic o_vsync,
    output logic o_enable,
    output logic o_newline,
    output logic o_newframe,
    output pos_t o_x,
    output pos_t o_y
);

    // Both totals must stay at or below 1024 to fit the 10-bit counters.
    localparam int   H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int   V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam pos_t H_LAST   = pos_t'(H_TOTAL - 1);
    localparam pos_t V_LAST   = pos_t'(V_TOTAL - 1);
    localparam pos_t H_VIS    = pos_t'(H_ACTIVE);
    localparam pos_t V_VIS    = pos_t'(V_ACTIVE);
    localparam pos_t HS_START = pos_t'(H_ACTIVE + H_FRONT);
    localparam pos_t HS_END   = pos_t'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam pos_t VS_START = pos_t'(V_ACTIVE + V_FRONT);
    localparam pos_t VS_END   = pos_t'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic SYNC_OFF = SYNC_NEG;
    localparam logic SYNC_ON  = !SYNC_NEG;

    pos_t h_q, h_d, v_q, v_d;
    pos_t x_q, x_d, y_q, y_d;
    logic enable_q, enable_d;
    logic newline_q, newline_d;
    logic newframe_q, newframe_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic h_last, v_last;
    logic [1:0] sync_pins;

    // Outputs are decoded from the current counters, so they trail them by one clock.
    always_comb begin
        h_last     = (h_q == H_LAST);
        v_last     = (v_q == V_LAST);
        h_d        = h_last ? '0 : h_q + 1'b1;
        v_d        = v_q;
        if (h_last) begin
            v_d = v_last ? '0 : v_q + 1'b1;
        end
        x_d        = h_q;
        y_d        = v_q;
        enable_d   = (h_q < H_VIS) && (v_q < V_VIS);
        newline_d  = h_last;
        newframe_d = h_last && v_last;
        hsync_d    = ((h_q >= HS_START) && (h_q < HS_END)) ? SYNC_ON : SYNC_OFF;
        vsync_d    = ((v_q >= VS_START) && (v_q < VS_END)) ? SYNC_ON : SYNC_OFF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q        <= '0;
            v_q        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            enable_q   <= 1'b0;
            newline_q  <= 1'b0;
            newframe_q <= 1'b0;
            hsync_q    <= SYNC_OFF;
            vsync_q    <= SYNC_OFF;
        end else begin
            h_q        <= h_d;
            v_q        <= v_d;
            x_q        <= x_d;
            y_q        <= y_d;
            enable_q   <= enable_d;
            newline_q  <= newline_d;
            newframe_q <= newframe_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
        end
    end

    sync_delay #(
        .DEPTH (SYNC_DELAY),
        .W     (2),
        .IDLE  ({SYNC_OFF, SYNC_OFF})
    ) u_sync_delay (
        .clk (clk),
        .rst (rst),
        .i_d ({hsync_q, vsync_q}),
        .o_q (sync_pins)
    );

    assign o_hsync    = sync_pins[1];
    assign o_vsync    = sync_pins[0];
    assign o_enable   = enable_q;
    assign o_newline  = newline_q;
    assign o_newframe = newframe_q;
    assign o_x        = x_q;
    assign o_y        = y_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default 640x480 instance and a tiny override instance,
// both compared every cycle against a position-arithmetic raster model.
`timescale 1ns/1ps
module tb_vga_timing;

    localparam int A_HA = 640, A_HF = 16, A_HS = 96, A_HB = 48;
    localparam int A_VA = 480, A_VF = 10, A_VS = 2,  A_VB = 33;
    localparam bit A_NEG = 1'b1;
    localparam int A_D = 1;
    localparam int B_HA = 8, B_HF = 2, B_HS = 2, B_HB = 2;
    localparam int B_VA = 4, B_VF = 1, B_VS = 1, B_VB = 1;
    localparam bit B_NEG = 1'b0;
    localparam int B_D = 0;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    logic a_hs, a_vs, a_en, a_nl, a_nf;
    logic [9:0] a_x, a_y;
    logic b_hs, b_vs, b_en, b_nl, b_nf;
    logic [9:0] b_x, b_y;

    int checks = 0;
    int failures = 0;
    int ticks_a = 0;
    int ticks_b = 0;
    logic [24:0] got_a, exp_a, got_b, exp_b;

    always #5 clk = ~clk;

    vga_timing dut_a (
        .clk (clk), .rst (rst_a),
        .o_hsync (a_hs), .o_vsync (a_vs), .o_enable (a_en),
        .o_newline (a_nl), .o_newframe (a_nf), .o_x (a_x), .o_y (a_y)
    );

    vga_timing #(
        .H_ACTIVE (B_HA), .H_FRONT (B_HF), .H_SYNC (B_HS), .H_BACK (B_HB),
        .V_ACTIVE (B_VA), .V_FRONT (B_VF), .V_SYNC (B_VS), .V_BACK (B_VB),
        .SYNC_NEG (B_NEG), .SYNC_DELAY (B_D)
    ) dut_b (
        .clk (clk), .rst (rst_b),
        .o_hsync (b_hs), .o_vsync (b_vs), .o_enable (b_en),
        .o_newline (b_nl), .o_newframe (b_nf), .o_x (b_x), .o_y (b_y)
    );

    // Expected {hsync, vsync, enable, newline, newframe, x, y} after 'ticks' edges out of reset.
    function automatic logic [24:0] model(input bit is_a, input int ticks);
        int ha, hf, hs, hb, va, vf, vs, vb, d, ht, vt, p, q, x, y, qx, qy;
        bit neg, en, nl, nf, hs_on, vs_on;
        if (is_a) begin
            ha = A_HA; hf = A_HF; hs = A_HS; hb = A_HB;
            va = A_VA; vf = A_VF; vs = A_VS; vb = A_VB; neg = A_NEG; d = A_D;
        end else begin
            ha = B_HA; hf = B_HF; hs = B_HS; hb = B_HB;
            va = B_VA; vf = B_VF; vs = B_VS; vb = B_VB; neg = B_NEG; d = B_D;
        end
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        if (ticks == 0) return {neg, neg, 3'b000, 10'd0, 10'd0};
        p = ticks - 1;
        x = p % ht;
        y = (p / ht) % vt;
        en = (x < ha) && (y < va);
        nl = (x == ht - 1);
        nf = nl && (y == vt - 1);
        q = p - d;
        hs_on = 1'b0;
        vs_on = 1'b0;
        if (q >= 0) begin
            qx = q % ht;
            qy = (q / ht) % vt;
            hs_on = (qx >= ha + hf) && (qx < ha + hf + hs);
            vs_on = (qy >= va + vf) && (qy < va + vf + vs);
        end
        return {hs_on ^ neg, vs_on ^ neg, en, nl, nf, 10'(x), 10'(y)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s t=%0t got=%0h want=%0h", name, $time, got, exp);
        end
    endtask

    // Randomly pulses each reset for 1..3 clocks while the raster runs.
    task automatic applyStimulus(input int cycles);
        int hold_a = 0;
        int hold_b = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #3;
            if (hold_a > 0) begin
                hold_a--;
                if (hold_a == 0) rst_a = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                rst_a = 1'b1;
                hold_a = int'($urandom_range(1, 3));
            end
            if (hold_b > 0) begin
                hold_b--;
                if (hold_b == 0) rst_b = 1'b0;
            end else if ($urandom_range(0, 59) == 0) begin
                rst_b = 1'b1;
                hold_b = int'($urandom_range(1, 3));
            end
        end
        @(posedge clk);
        #3;
        rst_a = 1'b0;
        rst_b = 1'b0;
    endtask

    always @(posedge clk) begin
        ticks_a = rst_a ? 0 : ticks_a + 1;
        ticks_b = rst_b ? 0 : ticks_b + 1;
    end

    always @(negedge clk) begin
        got_a = {a_hs, a_vs, a_en, a_nl, a_nf, a_x, a_y};
        exp_a = model(1'b1, rst_a ? 0 : ticks_a);
        checkOutput("A.raster", 32'(got_a), 32'(exp_a));
        got_b = {b_hs, b_vs, b_en, b_nl, b_nf, b_x, b_y};
        exp_b = model(1'b0, rst_b ? 0 : ticks_b);
        checkOutput("B.raster", 32'(got_b), 32'(exp_b));
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog t=%0t got=running want=finished", $time);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int k, per, ens;

        checkOutput("model.A.first", 32'(model(1'b1, 1)), 32'h1C00000);
        checkOutput("model.A.hsync", 32'(model(1'b1, 658)), 32'h08A4400);
        checkOutput("model.B.frame", 32'(model(1'b0, 98)), 32'h0303406);
        checkOutput("model.B.vsync", 32'(model(1'b0, 76)), 32'h0801405);

        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("A.rst.idle", {a_hs, a_vs, a_en, a_nl, a_nf, a_x, a_y}, 32'h1800000);
        checkOutput("B.rst.idle", {b_hs, b_vs, b_en, b_nl, b_nf, b_x, b_y}, 32'h0);
        @(posedge clk);
        #3;
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("A.first.en", a_en, 1);
        checkOutput("A.first.x", a_x, 0);
        checkOutput("B.first.en", b_en, 1);

        // Line period and per-line enable count on the full-size raster.
        @(negedge clk);
        for (k = 0; k < 2000 && !a_nl; k++) @(negedge clk);
        checkOutput("A.newline.seen", a_nl, 1);
        per = 0; ens = 0;
        do begin
            @(negedge clk);
            per++;
            ens += int'(a_en);
        end while (!a_nl && per < 2000);
        checkOutput("A.line.period", per, 800);
        checkOutput("A.line.enables", ens, 640);

        for (k = 0; k < 2000 && a_x != 10'd656; k++) @(negedge clk);
        checkOutput("A.x656.seen", a_x, 656);
        k = 0;
        while (a_hs && k < 10) begin @(negedge clk); k++; end
        checkOutput("A.hsync.delay", k, 1);
        k = 0;
        while (!a_hs && k < 200) begin @(negedge clk); k++; end
        checkOutput("A.hsync.width", k, 96);

        // Small raster: line/frame periods, frame-boundary behaviour, sync windows.
        for (k = 0; k < 200 && !b_nl; k++) @(negedge clk);
        per = 0;
        do begin @(negedge clk); per++; end while (!b_nl && per < 200);
        checkOutput("B.line.period", per, 14);

        for (k = 0; k < 200 && !b_nf; k++) @(negedge clk);
        checkOutput("B.newframe.seen", b_nf, 1);
        per = 0; ens = 0;
        do begin
            @(negedge clk);
            per++;
            ens += int'(b_en);
        end while (!b_nf && per < 300);
        checkOutput("B.frame.period", per, 98);
        checkOutput("B.frame.enables", ens, 32);
        checkOutput("B.nf.with.nl", b_nl, 1);
        checkOutput("B.nf.en", b_en, 0);
        @(negedge clk);
        checkOutput("B.after.nf", {b_en, b_x, b_y}, 32'h100000);

        for (k = 0; k < 200 && b_x != 10'd9; k++) @(negedge clk);
        checkOutput("B.hs.x9", b_hs, 0);
        @(negedge clk);
        checkOutput("B.hs.x10", b_hs, 1);
        @(negedge clk);
        checkOutput("B.hs.x11", b_hs, 1);
        @(negedge clk);
        checkOutput("B.hs.x12", b_hs, 0);

        for (k = 0; k < 200 && !b_vs; k++) @(negedge clk);
        checkOutput("B.vs.start", {b_x, b_y}, 32'h5);
        k = 0;
        while (b_vs && k < 100) begin @(negedge clk); k++; end
        checkOutput("B.vs.width", k, 14);

        // Mid-frame reset: outputs clear asynchronously and the frame restarts at 0,0.
        for (k = 0; k < 200 && !(b_y == 10'd2 && b_x == 10'd5); k++) @(negedge clk);
        checkOutput("B.pos.seen", {b_x, b_y}, 32'h1402);
        #1;
        rst_b = 1'b1;
        #1;
        checkOutput("B.async.idle", {b_en, b_nl, b_x, b_y}, 32'h0);
        @(posedge clk);
        #3;
        rst_b = 1'b0;
        @(negedge clk);
        for (k = 0; k < 10 && !b_en; k++) @(negedge clk);
        checkOutput("B.restart.pos", {b_en, b_x, b_y}, 32'h100000);
        per = 0;
        while (!b_nf && per < 300) begin @(negedge clk); per++; end
        checkOutput("B.restart.nf", per, 97);

        applyStimulus(4000);
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Generates the raster timing for the 640x480@60 VGA output: horizontal/vertical counters, the hsync/vsync pins, and the strobes the pixel generator consumes.
- Strobes are `o_newframe`, `o_newline` and `o_enable`; they feed the pixel generator's `i_newframe`, `i_newline` and `i_enable`.
- Sits between the pixel-clock domain (25 MHz) and the HDMI/VGA PMOD pins, upstream of the GPU that turns screen-RAM words into pixels.
- Sync outputs carry a programmable delay so they stay aligned with the GPU's memory-read latency.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_NEG, 1, 1 = sync pulses active-low, 0 = active-high
- SYNC_DELAY, 1, extra clocks of delay on o_hsync/o_vsync only (0..7)

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- o_hsync  out  1  horizontal sync pin
- o_vsync  out  1  vertical sync pin
- o_enable  out  1  active-video qualifier; GPU advances one pixel per high cycle
- o_newline  out  1  one-cycle pulse, last clock of every line
- o_newframe  out  1  one-cycle pulse, last clock of every frame
- o_x  out  10  horizontal position matching the strobes (0..H_TOTAL-1)
- o_y  out  10  vertical position matching the strobes (0..V_TOTAL-1)

Behaviour:
- Derived totals:
  - H_TOTAL = sum of the four H parameters (800).
  - V_TOTAL = sum of the four V parameters (525).
  - Counter width is 10 bits; the parameter set must keep both totals at or below 1024.
- Counters h, v reset to 0.
  - Each clock: h <= (h==H_TOTAL-1) ? 0 : h+1.
  - v increments only when h==H_TOTAL-1, and wraps to 0 when additionally v==V_TOTAL-1.
- Output register stage: all outputs are registered from (h,v) at the same edge, so they lag the counters by exactly one clock. o_x/o_y are those lagged values.
- o_enable: high iff x<H_ACTIVE and y<V_ACTIVE.
- o_newline: high iff x==H_TOTAL-1, on every line, including blanking lines.
- o_newframe: high iff x==H_TOTAL-1 and y==V_TOTAL-1.
  - Always coincides with o_newline.
  - o_enable is low when o_newframe is high.
  - The next cycle shows x=0, y=0, o_enable=1.
- hsync asserted iff H_ACTIVE+H_FRONT <= x < H_ACTIVE+H_FRONT+H_SYNC (656..751).
- vsync asserted iff V_ACTIVE+V_FRONT <= y < V_ACTIVE+V_FRONT+V_SYNC (490..491), for the whole of each such line.
- Asserted level is 0 when SYNC_NEG=1, otherwise 1.
- hsync and vsync then pass through a SYNC_DELAY-deep shift register before reaching the pins.
  - SYNC_DELAY=0 means no added stage.
  - o_enable, o_newline, o_newframe, o_x, o_y are never delayed.
- Reset values while rst is high:
  - o_enable = 0, o_newline = 0, o_newframe = 0, o_x = 0, o_y = 0.
  - o_hsync and o_vsync at their deasserted level, including every delay stage.
- Reset mid-frame: all state clears immediately (asynchronous).
  - First edge after release: counters advance to h=1, v=0, and outputs show x=0, y=0, o_enable=1.
  - No o_newframe is emitted for that first partial start; downstream counters are reset by their own reset.
- No handshake or backpressure: the timing is free-running and independent of the consumer.

Decomposition:
- Package vga_pkg holds:
  - the 640x480@60 timing constants (H_/V_ ACTIVE, FRONT, SYNC, BACK, TOTAL);
  - typedef pos_t (10-bit unsigned);
  - the GPU's screen geometry constants SCREEN_W=512 and SCREEN_H=256, so both blocks share one source.
- One sub-module is natural: sync_delay, a parameterised N-deep, W-wide shift register.
  - Reset loads a supplied idle value.
  - Instantiated once with W=2 for {hsync, vsync}.

Test Plan:
- Reset held 5 clocks, SYNC_NEG=1 -> o_hsync=1, o_vsync=1, o_enable=0, o_newline=0, o_newframe=0, o_x=0, o_y=0. First clock after release -> o_enable=1, o_x=0.
- Run 2 lines -> 800 clocks between o_newline pulses, 640 o_enable clocks per visible line.
  - With SYNC_DELAY=1: o_hsync falls one clock after o_x==656 and stays low exactly 96 clocks.
- Run 2 full frames -> 420000 clocks between o_newframe pulses, 307200 o_enable clocks per frame.
  - o_newframe coincides with o_newline.
  - The following cycle shows o_x=0, o_y=0, o_enable=1.
- Vertical -> o_vsync low for exactly 1600 clocks, beginning one clock after o_x=0, o_y=490. No o_enable during lines 480..524.
- Assert rst for 1 clock when o_y=200, o_x=300 -> outputs go idle before the next edge. After release the frame restarts at 0,0 and o_newframe next appears 419999 clocks after the first o_enable.
- Override: H_ACTIVE=8, H_FRONT=H_SYNC=H_BACK=2, V_ACTIVE=4, V_FRONT=V_SYNC=V_BACK=1, SYNC_NEG=0, SYNC_DELAY=0 -> newline period 14, newframe period 98, hsync high at o_x=10..11.
